// File: rtl/store_unit.sv
// store_unit: packs SB/SH/SW stores into upper-first byte lanes and drains them in order to data memory; defining STORE_BUFFER_EN selects a two-entry buffer instead of one.
module store_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STORE_REQ,
  input  logic [2:0]  STORE_SEL,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] DATA_IN,
  output logic        STALL,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic        MEM_BUSYWAIT,
  output logic        ILLEGAL_STORE
);
`ifdef STORE_BUFFER_EN
  localparam logic [1:0] D = 2'd2;
`else
  localparam logic [1:0] D = 2'd1;
`endif
  typedef enum logic {IDLE, WRITE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;
  state_t     state, state_d;
  entry_t     ent [2];
  entry_t     pk;
  logic [1:0] cnt, cnt_d;
  logic       legal, accept, push, pop, wi;
  // lane packing: the store value always lands in the most significant lanes
  always_comb begin
    legal   = STORE_SEL == 3'b000 || STORE_SEL == 3'b001 || STORE_SEL == 3'b010;
    pk.addr = ADDRESS;
    pk.data = STORE_SEL == 3'b000 ? {DATA_IN[7:0], 24'd0} :
              STORE_SEL == 3'b001 ? {DATA_IN[15:0], 16'd0} : DATA_IN;
    pk.be   = STORE_SEL == 3'b000 ? 4'b1000 :
              STORE_SEL == 3'b001 ? 4'b1100 : 4'b1111;
  end
  // buffer bookkeeping: a pop shifts the head out, a push fills the first free slot after the shift
  always_comb begin
    STALL  = cnt == D;
    accept = RESET && STORE_REQ && !STALL;
    push   = accept && legal;
    pop    = state == WRITE && !MEM_BUSYWAIT;
    wi     = cnt[0] ^ pop;
    cnt_d  = cnt + {1'b0, push} - {1'b0, pop};
  end
  // next state and memory-side outputs; the head is only exposed while writing
  always_comb begin
    state_d       = cnt_d != 2'd0 ? WRITE : IDLE;
    MEM_WRITE     = state == WRITE;
    MEM_ADDRESS   = state == WRITE ? ent[0].addr : 32'd0;
    MEM_WRITEDATA = state == WRITE ? ent[0].data : 32'd0;
    MEM_BYTE_EN   = state == WRITE ? ent[0].be : 4'd0;
  end
  // state, occupancy and the one-cycle illegal-store pulse
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      ILLEGAL_STORE <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ILLEGAL_STORE <= accept && !legal;
    end
  end
  // buffer storage; contents are don't-care whenever occupancy is zero
  always_ff @(posedge CLK) begin
    if (pop) ent[0] <= ent[1];
    if (push) ent[wi] <= pk;
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: scoreboard bench for store_unit; expected writes are queued at acceptance and checked at completion
module tb_store_unit;
`ifdef STORE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;
  logic        clk = 1'b0;
  logic        rst_n, store_req, stall, mem_write, mem_busywait, illegal_store;
  logic [2:0]  store_sel;
  logic [31:0] address, data_in, mem_address, mem_writedata;
  logic [3:0]  mem_byte_en;
  int          n_chk = 0, n_pass = 0, n_wr = 0;
  bit          rand_done;
  wr_t         exp_q [$];
  always #5 clk = ~clk;
  store_unit dut (
    .CLK(clk), .RESET(rst_n), .STORE_REQ(store_req), .STORE_SEL(store_sel),
    .ADDRESS(address), .DATA_IN(data_in), .STALL(stall), .MEM_WRITE(mem_write),
    .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata), .MEM_BYTE_EN(mem_byte_en),
    .MEM_BUSYWAIT(mem_busywait), .ILLEGAL_STORE(illegal_store)
  );
  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic wr_t model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    case (s)
      3'b000:  return '{a, {d[7:0], 24'h0}, 4'b1000};
      3'b001:  return '{a, {d[15:0], 16'h0}, 4'b1100};
      default: return '{a, d, 4'b1111};
    endcase
  endfunction
  // completion monitor: every write handshake must match the oldest expected store
  always @(negedge clk) begin
    if (rst_n && mem_write && !mem_busywait) begin
      n_wr++;
      if (exp_q.size() == 0) check("spurious_write", {mem_address, mem_writedata, mem_byte_en}, 68'd0);
      else check("write", {mem_address, mem_writedata, mem_byte_en}, exp_q.pop_front());
    end
  end
  task automatic do_store(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    store_req = 1'b1; store_sel = s; address = a; data_in = d;
    @(negedge clk);
    while (stall && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) check("stall_wait", {67'd0, stall}, 68'd0);
    else if (s <= 3'd2) exp_q.push_back(model(s, a, d));
    @(posedge clk); #1;
    store_req = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || mem_write) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", 68'(exp_q.size()), 68'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int w0;
    rst_n = 1'b0; store_req = 1'b0; store_sel = 3'd0; address = 32'd0; data_in = 32'd0; mem_busywait = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write", {67'd0, mem_write}, 68'd0);
    check("rst_stall", {67'd0, stall}, 68'd0);
    check("rst_illegal", {67'd0, illegal_store}, 68'd0);
    check("rst_outs", {mem_address, mem_writedata, mem_byte_en}, 68'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_store(3'b000, 32'h1000, 32'hAABBCCDD);
    @(negedge clk);
    check("sb_visible", {67'd0, mem_write}, 68'd1);
    check("sb_outs", {mem_address, mem_writedata, mem_byte_en}, {32'h1000, 32'hDD000000, 4'b1000});
    @(negedge clk);
    check("sb_one_cycle", {67'd0, mem_write}, 68'd0);
    check("idle_outs", {mem_address, mem_writedata, mem_byte_en}, 68'd0);
    @(posedge clk); #1;
    do_store(3'b001, 32'h2002, 32'h12345678);
    @(negedge clk);
    check("sh_outs", {mem_address, mem_writedata, mem_byte_en}, {32'h2002, 32'h56780000, 4'b1100});
    wait_idle();
    @(posedge clk); #1;
    do_store(3'b010, 32'h3000, 32'h12345678);
    @(negedge clk);
    check("sw_outs", {mem_address, mem_writedata, mem_byte_en}, {32'h3000, 32'h12345678, 4'b1111});
    wait_idle();
    @(posedge clk); #1;
    foreach (store_sel[i]) begin end
    for (int k = 0; k < 2; k++) begin
      w0 = n_wr;
      do_store(k == 0 ? 3'b011 : 3'b111, 32'h4000, 32'hFFFFFFFF);
      @(negedge clk);
      check("ill_pulse", {67'd0, illegal_store}, 68'd1);
      check("ill_nowrite", {67'd0, mem_write}, 68'd0);
      @(negedge clk);
      check("ill_one_cycle", {67'd0, illegal_store}, 68'd0);
      check("ill_count", 68'(n_wr - w0), 68'd0);
      @(posedge clk); #1;
    end
    mem_busywait = 1'b1;
    do_store(3'b010, 32'h5000, 32'hCAFEF00D);
    @(negedge clk);
    check("bw_stall1", {67'd0, stall}, {67'd0, !BUF});
    fork
      begin
        do_store(3'b001, 32'h5004, 32'h0000BEEF);
        do_store(3'b000, 32'h5008, 32'h00000077);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          check("bw_hold", {mem_address, mem_writedata, mem_byte_en}, {32'h5000, 32'hCAFEF00D, 4'b1111});
        end
        check("bw_stall_full", {67'd0, stall}, 68'd1);
        @(posedge clk); #1;
        mem_busywait = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b_write", {67'd0, mem_write}, {67'd0, BUF});
      end
    join
    wait_idle();
    @(posedge clk); #1;
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++)
          do_store(3'($urandom_range(0, 2)), $urandom, $urandom);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          mem_busywait = 1'($urandom_range(0, 1));
        end
      end
    join
    mem_busywait = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    mem_busywait = 1'b1;
    do_store(3'b010, 32'h6000, 32'h11111111);
    if (BUF) do_store(3'b010, 32'h6004, 32'h22222222);
    rst_n = 1'b0;
    store_req = 1'b1; store_sel = 3'b010; address = 32'h7000; data_in = 32'h33333333;
    @(posedge clk); #1;
    rst_n = 1'b1;
    store_req = 1'b0;
    exp_q.delete();
    w0 = n_wr;
    @(negedge clk);
    check("rst_mid_write", {67'd0, mem_write}, 68'd0);
    check("rst_mid_stall", {67'd0, stall}, 68'd0);
    mem_busywait = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_stale", 68'(n_wr - w0), 68'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have ports: CLK  input  1  rising-edge clock.
REQ-002 SHALL have ports: RESET  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-003 SHALL have ports: STORE_REQ  input  1  MEM-stage store request, valid for one cycle per store.
REQ-004 SHALL have ports: STORE_SEL  input  3  store type, funct3 encoding: 000 SB, 001 SH, 010 SW; all other codes illegal.
REQ-005 SHALL have ports: ADDRESS  input  32  store byte address, passed through unmodified.
REQ-006 SHALL have ports: DATA_IN  input  32  rs2 value; byte = DATA_IN[7:0], half = DATA_IN[15:0].
REQ-007 SHALL have ports: STALL  output  1  pipeline hold; a request presented while STALL=1 is not accepted and must be held.
REQ-008 SHALL have ports: MEM_WRITE  output  1  data-memory write strobe.
REQ-009 SHALL have ports: MEM_ADDRESS  output  32  write address.
REQ-010 SHALL have ports: MEM_WRITEDATA  output  32  lane-aligned write data.
REQ-011 SHALL have ports: MEM_BYTE_EN  output  4  byte-lane enables; bit 3 selects [31:24].
REQ-012 SHALL have ports: MEM_BUSYWAIT  input  1  memory not ready; write completes on an edge with MEM_WRITE=1 and MEM_BUSYWAIT=0.
REQ-013 SHALL have ports: ILLEGAL_STORE  output  1  one-cycle pulse for an illegal STORE_SEL.

Function
REQ-014 SHALL pack data upper-lane first, matching the load path: SB -> {DATA_IN[7:0],24'd0}, BYTE_EN 1000; SH -> {DATA_IN[15:0],16'd0}, BYTE_EN 1100; SW -> DATA_IN, BYTE_EN 1111.
REQ-015 SHALL accept a request on a rising edge when STORE_REQ=1 and STALL=0.
REQ-016 SHALL enqueue each accepted legal request as {address, packed data, byte enables} into an in-order buffer of depth D (see Configuration).
REQ-017 SHALL, for an accepted illegal STORE_SEL, enqueue nothing and assert ILLEGAL_STORE for exactly the following cycle.
REQ-018 SHALL use a two-state FSM: IDLE (MEM_WRITE=0) and WRITE (MEM_WRITE=1, presenting the buffer head).
REQ-019 SHALL transition IDLE -> WRITE on the edge after the buffer becomes non-empty; first write is visible one cycle after acceptance.
REQ-020 SHALL hold MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTE_EN stable while in WRITE and MEM_BUSYWAIT=1.
REQ-021 SHALL, on completion, pop the head and remain in WRITE when another entry exists (back-to-back, no idle cycle); otherwise return to IDLE.
REQ-022 SHALL drive MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTE_EN to 0 in IDLE.
REQ-023 SHALL compute STALL combinationally as (occupancy == D), independent of same-cycle completion.
REQ-024 SHALL, on simultaneous accept and completion, pop the head and push the new entry with occupancy unchanged.
REQ-025 SHALL never reorder, drop or duplicate a legal store.

Reset
REQ-026 SHALL, on an edge with RESET=0, force IDLE, occupancy 0, MEM_WRITE=0, STALL=0, ILLEGAL_STORE=0 and all data outputs to 0.
REQ-027 SHALL, on reset mid-write, discard the in-flight and buffered stores, with MEM_WRITE low on the cycle after the reset edge.
REQ-028 SHALL ignore STORE_REQ on any edge where RESET=0.

Configuration
REQ-029 SHALL, with macro STORE_BUFFER_EN defined, set D=2, so a second store is accepted while the first is pending.
REQ-030 SHALL, without STORE_BUFFER_EN, set D=1: STALL is asserted from acceptance until the cycle after completion; all other behaviour is identical.

Verification
REQ-031 SB: SEL=000, ADDRESS=0x1000, DATA_IN=0xAABBCCDD, BUSYWAIT=0 -> next cycle MEM_WRITE=1, ADDR=0x1000, WDATA=0xDD000000, BYTE_EN=1000 for exactly one cycle.
REQ-032 SH and SW: SH with DATA=0x12345678 -> WDATA=0x56780000, BYTE_EN=1100; SW -> WDATA=0x12345678, BYTE_EN=1111.
REQ-033 BUSYWAIT held 3 cycles with STORE_BUFFER_EN -> outputs stable for 4 cycles; 2nd store accepted; 3rd request sees STALL=1; both stores complete back-to-back in order.
REQ-034 Illegal: SEL=011 -> ILLEGAL_STORE=1 for one cycle; MEM_WRITE stays 0.
REQ-035 Reset: RESET=0 during WRITE with BUSYWAIT=1 and 2 entries -> next cycle MEM_WRITE=0, STALL=0; no later write of the discarded data.
REQ-036 No STORE_BUFFER_EN: two consecutive requests -> STALL=1 until the cycle after the first write completes; second write then follows.
